// File: rtl/thermo_serializer_pkg.sv
// Shared types and sizing for the thermometer-code serializer.
// A count of ones is turned into an N_BITS-wide thermometer frame, LSB first.
package thermo_pkg;

    localparam int N_BITS = 8;
    localparam int CW     = $clog2(N_BITS + 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } thermo_state_t;

endpackage

// File: rtl/thermo_serializer.sv
// Accepts a count over valid/ready and streams an N_BITS thermometer word LSB first.
// Every output is decoded from registered state only, so there is no input-to-output comb path.
module thermo_serializer
    import thermo_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic          out_last,
    output logic          clamped
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(N_BITS);
    localparam logic [CW-1:0] LAST_IDX   = CW'(N_BITS - 1);

    thermo_state_t state_reg, state_next;
    logic [CW-1:0] bit_idx_reg, bit_idx_next;
    logic [CW-1:0] count_reg, count_next;
    logic          clamped_reg, clamped_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            bit_idx_reg <= '0;
            count_reg   <= '0;
            clamped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
            count_reg   <= count_next;
            clamped_reg <= clamped_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        count_next   = count_reg;
        clamped_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    // Out-of-range counts saturate to an all-ones frame.
                    count_next   = (in_count > FULL_COUNT) ? FULL_COUNT : in_count;
                    clamped_next = (in_count > FULL_COUNT);
                    bit_idx_next = '0;
                    state_next   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (out_ready) begin
                    if (bit_idx_reg == LAST_IDX) begin
                        bit_idx_next = '0;
                        state_next   = S_IDLE;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next   = S_IDLE;
                bit_idx_next = '0;
            end
        endcase
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_SHIFT);
    assign out_bit   = (state_reg == S_SHIFT) && (bit_idx_reg < count_reg);
    assign out_last  = (state_reg == S_SHIFT) && (bit_idx_reg == LAST_IDX);
    assign clamped   = clamped_reg;

endmodule

// File: tb/tb_thermo_serializer.sv
// Scoreboard bench: the driver queues expected beats/frames, a negedge monitor pops and compares.
// Each completed frame is also popcounted and compared against the requested count.
module tb_thermo_serializer;
    import thermo_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_count = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_bit;
    logic          out_last;
    logic          clamped;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic b;
        logic last;
    } beat_t;

    beat_t exp_q[$];
    int    cnt_q[$];
    logic [N_BITS-1:0] word_q[$];

    thermo_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .clamped   (clamped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    function automatic int popcount(input logic [N_BITS-1:0] w);
        int n = 0;
        for (int i = 0; i < N_BITS; i++) n += int'(w[i]);
        return n;
    endfunction

    // Monitor: a beat transfers on the next posedge when valid & ready are seen at the negedge.
    logic [N_BITS-1:0] shreg = '0;
    int                nbits = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            shreg = '0;
            nbits = 0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk($sformatf("beat%0d_bit", nbits), 32'(out_bit), 32'(e.b));
                chk($sformatf("beat%0d_last", nbits), 32'(out_last), 32'(e.last));
                if (nbits < N_BITS) shreg[nbits] = out_bit;
                nbits++;
                if (e.last) begin
                    int c;
                    logic [N_BITS-1:0] w;
                    c = cnt_q.pop_front();
                    w = word_q.pop_front();
                    chk("frame_word", 32'(shreg), 32'(w));
                    chk("frame_popcount", 32'(popcount(shreg)), 32'(c));
                    shreg = '0;
                    nbits = 0;
                end
            end
        end
    end

    // Offer a count, push the expected frame, return 1 ns after the accepting edge.
    task automatic send(input int c, input logic exp_clamp);
        int eff;
        int guard;
        logic [N_BITS-1:0] w;
        eff = (c > N_BITS) ? N_BITS : c;
        w = '0;
        for (int i = 0; i < N_BITS; i++) begin
            beat_t e;
            e.b    = (i < eff);
            e.last = (i == N_BITS - 1);
            w[i]   = e.b;
            exp_q.push_back(e);
        end
        cnt_q.push_back(eff);
        word_q.push_back(w);
        in_count = CW'(c);
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("clamped_after_%0d", c), 32'(clamped), 32'(exp_clamp));
        chk("valid_after_accept", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!in_ready && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state, then 5 quiet cycles after release.
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_clamped", 32'(clamped), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("idle_in_ready", 32'(in_ready), 32'd1);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_out_bit", 32'(out_bit), 32'd0);
        end

        // count=3: cycle-accurate latency; in_ready returns on cycle 9.
        out_ready = 1'b1;
        send(3, 1'b0);
        for (int k = 1; k <= N_BITS; k++) begin
            chk($sformatf("c3_busy_cycle%0d", k), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("c3_ready_cycle9", 32'(in_ready), 32'd1);
        chk("c3_clamped_gone", 32'(clamped), 32'd0);

        // Full sweep of legal counts.
        for (int c = 0; c <= N_BITS; c++) begin
            send(c, 1'b0);
            wait_idle();
        end

        // Saturating count.
        send(13, 1'b1);
        @(posedge clk); #1;
        chk("clamp_one_cycle", 32'(clamped), 32'd0);
        wait_idle();

        // count=5 with stalls; a mid-frame in_valid must be ignored.
        send(5, 1'b0);
        begin
            logic pat [4];
            logic pb, pl, prev_stall;
            pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
            prev_stall = 1'b0;
            pb = 1'b0;
            pl = 1'b0;
            for (int cyc = 0; cyc < 64; cyc++) begin
                if (prev_stall) begin
                    chk("stall_bit_stable", 32'(out_bit), 32'(pb));
                    chk("stall_last_stable", 32'(out_last), 32'(pl));
                end
                if (in_ready) break;
                pb = out_bit;
                pl = out_last;
                out_ready  = pat[cyc % 4];
                prev_stall = !out_ready;
                in_valid   = (cyc == 2 || cyc == 3);
                in_count   = CW'(2);
                if (in_valid) chk("midframe_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        wait_idle();
        @(posedge clk); #1;
        chk("stall_no_extra_frame", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a count=6 frame, at bit 4.
        send(6, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_out_bit", 32'(out_bit), 32'd0);
        chk("async_rst_out_last", 32'(out_last), 32'd0);
        exp_q.delete();
        cnt_q.delete();
        word_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(2, 1'b0);
        wait_idle();
        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
